csr_arbiter: RTL and testbench
==============================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, CSR address width.
REQ-002 Parameter DATA_W, default 8, CSR data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_a  input  ADDR_W  I2C-side CSR address; no stall capability.
REQ-006 m0_we  input  1  I2C-side single-cycle write strobe.
REQ-007 m0_do  input  DATA_W  I2C-side write data.
REQ-008 m0_di  output  DATA_W  I2C-side read data.
REQ-009 m1_req  input  1  internal requester access request, level, held until m1_ack.
REQ-010 m1_we  input  1  internal requester write (1) / read (0), stable while m1_req.
REQ-011 m1_a  input  ADDR_W  internal requester address, stable while m1_req.
REQ-012 m1_do  input  DATA_W  internal requester write data, stable while m1_req.
REQ-013 m1_ack  output  1  single-cycle completion pulse.
REQ-014 m1_di  output  DATA_W  registered read data, valid in the m1_ack cycle and held until the next m1_ack.
REQ-015 s_a  output  ADDR_W  shared CSR bank address.
REQ-016 s_we  output  1  shared CSR bank write strobe.
REQ-017 s_do  output  DATA_W  shared CSR bank write data.
REQ-018 s_di  input  DATA_W  shared CSR bank combinational read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, GRANT, DONE.
REQ-020 Outside GRANT, the block SHALL drive s_a=m0_a, s_we=m0_we, s_do=m0_do.
REQ-021 The block SHALL register m0_a every cycle into m0_a_q.
REQ-022 IDLE->GRANT SHALL occur when m1_req=1, m0_we=0 and m0_a==m0_a_q; otherwise the FSM SHALL stay in IDLE.
REQ-023 In GRANT with m0_we=0, the block SHALL drive s_a=m1_a, s_we=m1_we, s_do=m1_do, capture s_di into m1_di, and go to DONE.
REQ-024 In GRANT with m0_we=1, m0 SHALL win: s_a=m0_a, s_we=1, s_do=m0_do. m1_di SHALL NOT update, no ack SHALL be issued, and the FSM SHALL return to IDLE so m1 retries.
REQ-025 In DONE, m1_ack SHALL be 1 for exactly that cycle; next state SHALL be IDLE unconditionally.
REQ-026 m1_ack SHALL be 0 in all other states.
REQ-027 Latency: with m1_req rising in cycle N and the bus free, GRANT SHALL occur in N+1, ack in N+2, and the next GRANT no earlier than N+3.
REQ-028 A hold register m0_hold SHALL load s_di in every cycle the FSM is not in GRANT.
REQ-029 m0_di SHALL equal s_di outside GRANT and m0_hold in GRANT, so I2C reads never see m1 data.
REQ-030 Deassertion of m1_req during GRANT SHALL NOT abort the access: the access completes and m1_ack pulses.
REQ-031 m1_req=0 in IDLE SHALL keep the FSM in IDLE with no bus change.
REQ-032 Back-to-back m1 requests SHALL be served at most one access per 3 cycles.
REQ-033 m0 SHALL never be delayed or blocked; m0_we SHALL reach s_we in the same cycle in every state.

Reset
REQ-034 On rst: state=IDLE, m1_ack=0, m1_di=0, m0_hold=0, m0_a_q=0.
REQ-035 rst asserted in GRANT or DONE SHALL cancel the access with no m1_ack; an m1 write issued during GRANT in that same cycle is not suppressed.
REQ-036 With rst=1, the outputs s_a/s_we/s_do SHALL follow m0 combinationally.

Verification
REQ-037 m1 read: m1_a=0x10, bank[0x10]=0xA5, m1_req rises cycle 0 -> s_a=0x10 in cycle 1, m1_ack=1 and m1_di=0xA5 in cycle 2.
REQ-038 m1 write: m1_a=0x20, m1_do=0x3C -> s_we=1, s_a=0x20, s_do=0x3C in cycle 1; bank[0x20]=0x3C; ack in cycle 2.
REQ-039 Collision: m0_we=1 to 0x05=0x77 in the GRANT cycle of an m1 write to 0x06 -> bank[0x05]=0x77, bank[0x06] unchanged that cycle, no ack, m1 retried and acked later.
REQ-040 I2C read integrity: m0_a=0x01 (bank 0x11), m1 reads 0x02 (bank 0x22) -> m0_di=0x11 in every cycle including GRANT.
REQ-041 m0_a change: m0_a changes in cycle N with m1_req=1 -> no GRANT in cycle N+1; GRANT occurs in N+2 at the earliest.
REQ-042 Reset in GRANT: rst=1 in the GRANT cycle -> no m1_ack, state=IDLE, m1_di=0.

Source files
------------

// File: rtl/csr_arbiter.sv
// csr_arbiter: shares one CSR bank between a stall-free I2C-side master (m0)
// and an internal request/ack master (m1). m0 always owns the bus except in
// the single GRANT cycle, and even then an m0 write takes the bus back.
module csr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // I2C side
  input  logic [ADDR_W-1:0] m0_a,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_do,
  output logic [DATA_W-1:0] m0_di,
  // internal requester
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_a,
  input  logic [DATA_W-1:0] m1_do,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_di,
  // shared bank
  output logic [ADDR_W-1:0] s_a,
  output logic              s_we,
  output logic [DATA_W-1:0] s_do,
  input  logic [DATA_W-1:0] s_di
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_m0_a_q;
  logic [DATA_W-1:0] r_m0_hold;
  logic [DATA_W-1:0] r_m1_di;
  logic              w_in_grant;
  logic              w_m1_sel;

  assign w_in_grant = (r_state == GRANT);
  // m1 only drives the bank when m0 is not writing in the same cycle
  assign w_m1_sel   = w_in_grant && !m0_we;

  // State register; reset cancels any in-flight m1 access
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: grant only while m0 is idle on a stable address, since an
  // unchanged address means m0 is not mid-transaction on the bus
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (m1_req && !m0_we && (m0_a == r_m0_a_q)) w_next = GRANT;
      GRANT:   w_next = m0_we ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bank mux: m0 by default, m1 only in an uncontested GRANT cycle
  always_comb begin
    s_a  = m0_a;
    s_we = m0_we;
    s_do = m0_do;
    if (w_m1_sel) begin
      s_a  = m1_a;
      s_we = m1_we;
      s_do = m1_do;
    end
  end

  // Track m0 address once per cycle to detect address changes
  always_ff @(posedge clk) begin
    if (rst) r_m0_a_q <= '0;
    else     r_m0_a_q <= m0_a;
  end

  // Hold m0's read data so the GRANT cycle never exposes m1's location
  always_ff @(posedge clk) begin
    if (rst)              r_m0_hold <= '0;
    else if (!w_in_grant) r_m0_hold <= s_di;
  end

  // m1 read data is captured at the end of a winning GRANT cycle
  always_ff @(posedge clk) begin
    if (rst)           r_m1_di <= '0;
    else if (w_m1_sel) r_m1_di <= s_di;
  end

  assign m0_di  = w_in_grant ? r_m0_hold : s_di;
  assign m1_di  = r_m1_di;
  assign m1_ack = (r_state == DONE);

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter with a behavioural CSR bank.
module tb_csr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] m0_a, m0_do, m0_di;
  logic       m0_we;
  logic       m1_req, m1_we, m1_ack;
  logic [7:0] m1_a, m1_do, m1_di;
  logic [7:0] s_a, s_do, s_di;
  logic       s_we;

  logic [7:0] bank [256];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  csr_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_we(m0_we), .m0_do(m0_do), .m0_di(m0_di),
    .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_do(m1_do),
    .m1_ack(m1_ack), .m1_di(m1_di),
    .s_a(s_a), .s_we(s_we), .s_do(s_do), .s_di(s_di)
  );

  // Bank: combinational read, synchronous write, preset contents under reset
  assign s_di = bank[s_a];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
      bank[8'h10] <= 8'hA5;
      bank[8'h01] <= 8'h11;
      bank[8'h02] <= 8'h22;
      bank[8'h06] <= 8'h66;
      bank[8'h33] <= 8'h5A;
    end else if (s_we) begin
      bank[s_a] <= s_do;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven 2ns after the edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] ack_pat;

  initial begin
    ack_pat = 6'b100100;  // bit i = expected ack in cycle i
    rst = 1'b1; m0_a = 8'h33; m0_we = 1'b0; m0_do = 8'h44;
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 8'h10; m1_do = 8'h00;

    // reset: bus follows m0, no grant despite m1_req
    cyc(); cyc(); #1;
    chk("rst_s_a", s_a, 8'h33);
    chk("rst_s_do", s_do, 8'h44);
    chk("rst_ack", m1_ack, 0);
    chk("rst_m1_di", m1_di, 8'h00);
    chk("rst_m0_di", m0_di, 8'h5A);

    rst = 1'b0; m1_req = 1'b0; m0_a = 8'h00;
    cyc(); cyc();

    // m1 read of 0x10
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 8'h10; #1;
    chk("rd_c0_s_a", s_a, 8'h00);
    chk("rd_c0_ack", m1_ack, 0);
    cyc(); #1;
    chk("rd_c1_s_a", s_a, 8'h10);
    chk("rd_c1_ack", m1_ack, 0);
    cyc(); m1_req = 1'b0; #1;
    chk("rd_c2_ack", m1_ack, 1);
    chk("rd_c2_di", m1_di, 8'hA5);
    cyc(); #1;
    chk("rd_c3_ack", m1_ack, 0);
    chk("rd_c3_s_a", s_a, 8'h00);

    // m1 write 0x3C -> 0x20
    m1_req = 1'b1; m1_we = 1'b1; m1_a = 8'h20; m1_do = 8'h3C; #1;
    cyc(); #1;
    chk("wr_c1_s_we", s_we, 1);
    chk("wr_c1_s_a", s_a, 8'h20);
    chk("wr_c1_s_do", s_do, 8'h3C);
    chk("wr_c1_ack", m1_ack, 0);
    cyc(); m1_req = 1'b0; m1_we = 1'b0; #1;
    chk("wr_c2_ack", m1_ack, 1);
    chk("wr_bank20", bank[8'h20], 8'h3C);
    cyc();

    // back-to-back reads: one access per 3 cycles
    m1_req = 1'b1; m1_a = 8'h10;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("b2b_ack%0d", i), m1_ack, ack_pat[i]);
      cyc();
    end
    m1_req = 1'b0;
    cyc();

    // collision: m0 write in the GRANT of an m1 write
    m1_req = 1'b1; m1_we = 1'b1; m1_a = 8'h06; m1_do = 8'h99;
    cyc();
    m0_a = 8'h05; m0_we = 1'b1; m0_do = 8'h77; #1;
    chk("col_s_a", s_a, 8'h05);
    chk("col_s_we", s_we, 1);
    chk("col_s_do", s_do, 8'h77);
    chk("col_ack", m1_ack, 0);
    cyc(); m0_we = 1'b0; #1;
    chk("col_noack", m1_ack, 0);
    chk("col_bank05", bank[8'h05], 8'h77);
    chk("col_bank06", bank[8'h06], 8'h66);
    cyc(); #1;
    chk("col_retry_s_a", s_a, 8'h06);
    chk("col_retry_s_do", s_do, 8'h99);
    cyc(); m1_req = 1'b0; m1_we = 1'b0; #1;
    chk("col_retry_ack", m1_ack, 1);
    chk("col_bank06_new", bank[8'h06], 8'h99);
    cyc();

    // I2C read integrity while m1 reads 0x02
    m0_a = 8'h01;
    cyc(); cyc();
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 8'h02;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) m1_req = 1'b0;
      #1;
      chk($sformatf("i2c_m0_di%0d", i), m0_di, 8'h11);
      if (i == 1) chk("i2c_grant_s_a", s_a, 8'h02);
      if (i == 2) begin
        chk("i2c_ack", m1_ack, 1);
        chk("i2c_m1_di", m1_di, 8'h22);
      end
      cyc();
    end

    // m0 address change delays the grant by one cycle
    m1_req = 1'b1; m1_a = 8'h10; m0_a = 8'h02; #1;
    chk("chg_n_s_a", s_a, 8'h02);
    cyc(); #1;
    chk("chg_n1_s_a", s_a, 8'h02);
    chk("chg_n1_ack", m1_ack, 0);
    cyc(); #1;
    chk("chg_n2_s_a", s_a, 8'h10);
    cyc(); m1_req = 1'b0; #1;
    chk("chg_ack", m1_ack, 1);
    chk("chg_m1_di", m1_di, 8'hA5);
    cyc();

    // reset during GRANT cancels the access
    m0_a = 8'h01;
    cyc(); cyc();
    m1_req = 1'b1; m1_a = 8'h02;
    cyc(); #1;
    chk("rg_s_a", s_a, 8'h02);
    rst = 1'b1;
    cyc(); rst = 1'b0; m1_req = 1'b0; #1;
    chk("rg_ack", m1_ack, 0);
    chk("rg_m1_di", m1_di, 8'h00);
    chk("rg_s_a_idle", s_a, 8'h01);
    cyc(); #1;
    chk("rg_ack_after", m1_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
